btn_repeat: RTL and testbench

- Button-event stage between the debouncer and the alarm/time-set logic.
- Converts the 5 debounced button levels into single-cycle press pulses.
- Holding a repeat-enabled button (up/down by default) produces auto-repeat pulses, so alarm hour/minute digits can be scrolled.
- Also reports which buttons are currently in auto-repeat.

---
 rtl/btn_repeat_if.sv | 13 +
 rtl/btn_repeat.sv | 131 +++++++++++++
 tb/tb_btn_repeat.sv | 100 ++++++++++
 3 files changed

// File: rtl/btn_repeat_if.sv
// Button bus between the debouncer side and the event stage.
// master drives the debounced levels; slave returns pulses, held flags and the OR.
interface btn_repeat_if #(
  parameter int NUM_LANES = 5
);
  logic [NUM_LANES-1:0] btn_in;
  logic [NUM_LANES-1:0] btn_pulse;
  logic [NUM_LANES-1:0] btn_held;
  logic                 any_pulse;

  modport master (output btn_in, input btn_pulse, btn_held, any_pulse);
  modport slave  (input btn_in, output btn_pulse, btn_held, any_pulse);
endinterface

// File: rtl/btn_repeat.sv
// Button event stage: press pulses plus hold-to-repeat on selected channels.
// One independent lane FSM per button; all outputs are registered.
module btn_repeat_lane #(
  parameter int HOLD_CYC   = 5,
  parameter int REPEAT_CYC = 2,
  parameter bit RPT_EN     = 1'b1,
  parameter int CNT_W      = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse,
  output logic held,
  output logic pulse_nxt
);
  typedef enum logic [1:0] {IDLE, PRESS, REPEAT} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_SAT  = CNT_W'(HOLD_CYC);
  localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_CYC - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             prev;
  logic             held_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      prev  <= 1'b0;
      pulse <= 1'b0;
      held  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      prev  <= btn;
      pulse <= pulse_nxt;
      held  <= held_nxt;
    end
  end

  // Counter holds "edges since last event minus one", so expiry is one short of the period.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pulse_nxt = 1'b0;
    held_nxt  = held;
    if (!btn) begin
      // release beats any coincident expiry
      state_nxt = IDLE;
      cnt_nxt   = '0;
      held_nxt  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!prev) begin
            pulse_nxt = 1'b1;
            cnt_nxt   = '0;
            state_nxt = PRESS;
          end
        end
        PRESS: begin
          if (RPT_EN && cnt == HOLD_LAST) begin
            pulse_nxt = 1'b1;
            held_nxt  = 1'b1;
            cnt_nxt   = '0;
            state_nxt = REPEAT;
          end else if (cnt != HOLD_SAT) begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        REPEAT: begin
          if (cnt == RPT_LAST) begin
            pulse_nxt = 1'b1;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end
endmodule

module btn_repeat #(
  parameter int                 sys_freq    = 100000000,
  parameter int                 HOLD_MS     = 500,
  parameter int                 REPEAT_MS   = 100,
  parameter logic [4:0]         REPEAT_MASK = 5'b11000
) (
  input  logic      clk,
  input  logic      rst,
  btn_repeat_if.slave bus
);
  localparam int NUM_LANES  = 5;
  localparam int HOLD_CYC   = sys_freq / 1000 * HOLD_MS;
  localparam int REPEAT_CYC = sys_freq / 1000 * REPEAT_MS;
  localparam int MAX_CYC    = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int CNT_W      = $clog2(MAX_CYC + 1);

  logic [NUM_LANES-1:0] pulse, held, pulse_nxt;
  logic                 any_q;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    btn_repeat_lane #(
      .HOLD_CYC  (HOLD_CYC),
      .REPEAT_CYC(REPEAT_CYC),
      .RPT_EN    (REPEAT_MASK[i]),
      .CNT_W     (CNT_W)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .btn      (bus.btn_in[i]),
      .pulse    (pulse[i]),
      .held     (held[i]),
      .pulse_nxt(pulse_nxt[i])
    );
  end

  // Registered from the lanes' next-pulse so it lines up with btn_pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) any_q <= 1'b0;
    else     any_q <= |pulse_nxt;
  end

  assign bus.btn_pulse = pulse;
  assign bus.btn_held  = held;
  assign bus.any_pulse = any_q;
endmodule

// File: tb/tb_btn_repeat.sv
// Directed bench for btn_repeat: HOLD_CYC=5, REPEAT_CYC=2, default mask.
module tb_btn_repeat;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  localparam logic [4:0] UP   = 5'b10000;
  localparam logic [4:0] UPDN = 5'b11000;
  localparam logic [4:0] CTR  = 5'b00001;

  btn_repeat_if bus ();

  btn_repeat #(
    .sys_freq   (1000),
    .HOLD_MS    (5),
    .REPEAT_MS  (2),
    .REPEAT_MASK(5'b11000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Drive b for n_on edges then 0 until n_tot; bit i of pmask/hmask marks the
  // offsets at which chans must show a pulse / held flag right after that edge.
  task automatic run(input string tag, input logic [4:0] b, input int n_on, input int n_tot,
                     input logic [31:0] pmask, input logic [31:0] hmask);
    logic [4:0] ep, eh;
    for (int i = 0; i < n_tot; i++) begin
      bus.btn_in = (i < n_on) ? b : 5'b0;
      @(posedge clk); #1;
      ep = pmask[i] ? b : 5'b0;
      eh = hmask[i] ? b : 5'b0;
      chk($sformatf("%s[%0d] pulse", tag, i), bus.btn_pulse, ep);
      chk($sformatf("%s[%0d] held", tag, i), bus.btn_held, eh);
      chk($sformatf("%s[%0d] any", tag, i), {4'b0, bus.any_pulse}, {4'b0, |ep});
    end
  endtask

  task automatic idle(input int n);
    bus.btn_in = 5'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.btn_in = 5'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset pulse", bus.btn_pulse, 5'b0);
    chk("reset held", bus.btn_held, 5'b0);
    chk("reset any", {4'b0, bus.any_pulse}, 5'b0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    run("tap", UP, 3, 6, 32'h1, 32'h0);
    idle(2);

    run("hold_up", UP, 12, 14, 32'hAA1, 32'hFE0);
    idle(2);

    run("center", CTR, 20, 22, 32'h1, 32'h0);
    idle(2);

    // release exactly at the hold expiry, then a fresh press
    run("rel_exp", UP, 5, 6, 32'h1, 32'h0);
    run("repress", UP, 2, 3, 32'h1, 32'h0);
    idle(2);

    run("simul", UPDN, 8, 9, 32'hA1, 32'hE0);
    idle(2);

    // reset mid-repeat with the button still down
    run("pre_rst", UP, 7, 7, 32'h21, 32'h60);
    #2 rst = 1'b1;
    #1;
    chk("async pulse", bus.btn_pulse, 5'b0);
    chk("async held", bus.btn_held, 5'b0);
    chk("async any", {4'b0, bus.any_pulse}, 5'b0);
    @(negedge clk);
    rst = 1'b0;
    run("post_rst", UP, 8, 9, 32'hA1, 32'hE0);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
